// File: rtl/fetch_align_buffer_if.sv
// Fetch/decode side bundle of the halfword fetch-align buffer.
// The master side is the surrounding pipeline (Icache, Decode, redirect logic);
// the slave side is the buffer itself.
interface fetch_align_buffer_if;
    logic        Icache_Valid;
    logic [63:0] Icache_Instr;
    logic        Fetch_Ready;
    logic        Flush;
    logic [31:0] Flush_PC;
    logic        Align_Valid0;
    logic [31:0] Align_Instr0;
    logic [31:0] Align_PC0;
    logic        Align_Is16_0;
    logic        Align_Valid1;
    logic [31:0] Align_Instr1;
    logic [31:0] Align_PC1;
    logic        Align_Is16_1;
    logic [1:0]  Decode_Take;

    modport master (
        output Icache_Valid, Icache_Instr, Flush, Flush_PC, Decode_Take,
        input  Fetch_Ready, Align_Valid0, Align_Instr0, Align_PC0, Align_Is16_0,
               Align_Valid1, Align_Instr1, Align_PC1, Align_Is16_1
    );

    modport slave (
        input  Icache_Valid, Icache_Instr, Flush, Flush_PC, Decode_Take,
        output Fetch_Ready, Align_Valid0, Align_Instr0, Align_PC0, Align_Is16_0,
               Align_Valid1, Align_Instr1, Align_PC1, Align_Is16_1
    );
endinterface

// File: rtl/fetch_align_buffer.sv
// Halfword-granular instruction realignment buffer. Takes 64-bit fetch packets,
// stores them as halfwords in a circular array and presents up to two decoded
// RVC/RV32 instructions per cycle, each with its PC and a compressed flag.
module fetch_align_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_align_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_DROP_PEND = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

    // Instruction length in halfwords: low bits 2'b11 mark a 32-bit encoding.
    function automatic logic [1:0] len_of(input logic [15:0] hw);
        return (hw[1:0] == 2'b11) ? 2'd2 : 2'd1;
    endfunction

    logic [15:0]   mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   head_pc_r;
    logic [1:0]    drop_r;
    state_t        state_r;

    logic [15:0] hw0_s, hw1_s, hw2_s, hw3_s;
    logic [15:0] s1_lo_s, s1_hi_s;
    logic [1:0]  len0_s, len1_s;
    logic [2:0]  len01_s;
    logic        valid0_s, valid1_s;
    logic [1:0]  take_s;
    logic [2:0]  consumed_s;
    logic [1:0]  skip_s;
    logic [2:0]  wr_cnt_s;
    logic        enq_s;

    // Slot decode, take clamping and enqueue sizing from registered state.
    always_comb begin
        hw0_s    = mem_r[head_r];
        hw1_s    = mem_r[head_r + PW'(1)];
        hw2_s    = mem_r[head_r + PW'(2)];
        hw3_s    = mem_r[head_r + PW'(3)];
        len0_s   = len_of(hw0_s);
        s1_lo_s  = hw1_s;
        s1_hi_s  = hw2_s;
        if (len0_s == 2'd2) begin
            s1_lo_s = hw2_s;
            s1_hi_s = hw3_s;
        end else begin
            s1_lo_s = hw1_s;
            s1_hi_s = hw2_s;
        end
        len1_s   = len_of(s1_lo_s);
        len01_s  = {1'b0, len0_s} + {1'b0, len1_s};
        valid0_s = (cnt_r >= CW'(len0_s));
        valid1_s = valid0_s && (cnt_r >= CW'(len01_s));

        // Illegal over-take is clamped to what is actually presented.
        take_s = bus.Decode_Take;
        if (!valid0_s) begin
            take_s = 2'd0;
        end else if (!valid1_s && (bus.Decode_Take != 2'd0)) begin
            take_s = 2'd1;
        end else if (bus.Decode_Take == 2'd3) begin
            take_s = 2'd2;
        end else begin
            take_s = bus.Decode_Take;
        end

        case (take_s)
            2'd1:    consumed_s = {1'b0, len0_s};
            2'd2:    consumed_s = len01_s;
            default: consumed_s = 3'd0;
        endcase

        // After a redirect the halfwords below the target PC are discarded.
        case (state_r)
            ST_DROP_PEND: skip_s = drop_r;
            ST_RUN:       skip_s = 2'd0;
            default:      skip_s = 2'd0;
        endcase
        wr_cnt_s = 3'd4 - {1'b0, skip_s};
        enq_s    = bus.Icache_Valid && bus.Fetch_Ready && !bus.Flush;
    end

    // Output presentation is combinational from registered buffer state.
    always_comb begin
        bus.Fetch_Ready  = (cnt_r <= CW'(DEPTH - 4));
        bus.Align_Valid0 = valid0_s;
        bus.Align_PC0    = head_pc_r;
        bus.Align_Is16_0 = (len0_s == 2'd1);
        bus.Align_Valid1 = valid1_s;
        bus.Align_PC1    = head_pc_r + {29'd0, len0_s, 1'b0};
        bus.Align_Is16_1 = (len1_s == 2'd1);
        if (len0_s == 2'd2) begin
            bus.Align_Instr0 = {hw1_s, hw0_s};
        end else begin
            bus.Align_Instr0 = {16'h0000, hw0_s};
        end
        if (len1_s == 2'd2) begin
            bus.Align_Instr1 = {s1_hi_s, s1_lo_s};
        end else begin
            bus.Align_Instr1 = {16'h0000, s1_lo_s};
        end
    end

    // Buffer state: reset, flush redirect, packet write and decode consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            head_r    <= '0;
            tail_r    <= '0;
            cnt_r     <= '0;
            head_pc_r <= RESET_PC;
            drop_r    <= RESET_PC[2:1];
            state_r   <= ST_DROP_PEND;
        end else if (bus.Flush) begin
            head_r    <= '0;
            tail_r    <= '0;
            cnt_r     <= '0;
            head_pc_r <= bus.Flush_PC;
            drop_r    <= bus.Flush_PC[2:1];
            state_r   <= ST_DROP_PEND;
        end else begin
            if (enq_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) >= {1'b0, skip_s}) begin
                        mem_r[tail_r + PW'(i) - PW'(skip_s)] <= bus.Icache_Instr[16*i +: 16];
                    end
                end
                tail_r  <= tail_r + PW'(wr_cnt_s);
                cnt_r   <= cnt_r + CW'(wr_cnt_s) - CW'(consumed_s);
                state_r <= ST_RUN;
            end else begin
                cnt_r   <= cnt_r - CW'(consumed_s);
            end
            head_r    <= head_r + PW'(consumed_s);
            head_pc_r <= head_pc_r + {28'd0, consumed_s, 1'b0};
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer (DEPTH 8, RESET_PC 0).
module tb_fetch_align_buffer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fetch_align_buffer_if bus ();

    fetch_align_buffer #(
        .DEPTH    (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then return inputs to idle; sample at edge+1.
    task automatic cycle(input logic valid, input logic [63:0] pkt, input logic [1:0] take,
                         input logic flush, input logic [31:0] fpc);
        bus.Icache_Valid = valid;
        bus.Icache_Instr = pkt;
        bus.Decode_Take  = take;
        bus.Flush        = flush;
        bus.Flush_PC     = fpc;
        @(posedge clk);
        #1;
        bus.Icache_Valid = 1'b0;
        bus.Icache_Instr = 64'd0;
        bus.Decode_Take  = 2'd0;
        bus.Flush        = 1'b0;
        bus.Flush_PC     = 32'd0;
    endtask

    task automatic slot0(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic is16);
        check({tag, ".v0"},   {31'd0, bus.Align_Valid0}, {31'd0, v});
        check({tag, ".i0"},   bus.Align_Instr0, ins);
        check({tag, ".pc0"},  bus.Align_PC0, pc);
        check({tag, ".c0"},   {31'd0, bus.Align_Is16_0}, {31'd0, is16});
    endtask

    task automatic slot1(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic is16);
        check({tag, ".v1"},   {31'd0, bus.Align_Valid1}, {31'd0, v});
        check({tag, ".i1"},   bus.Align_Instr1, ins);
        check({tag, ".pc1"},  bus.Align_PC1, pc);
        check({tag, ".c1"},   {31'd0, bus.Align_Is16_1}, {31'd0, is16});
    endtask

    task automatic ready(input string tag, input logic exp);
        check({tag, ".rdy"}, {31'd0, bus.Fetch_Ready}, {31'd0, exp});
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        bus.Icache_Valid = 1'b0;
        bus.Icache_Instr = 64'd0;
        bus.Decode_Take  = 2'd0;
        bus.Flush        = 1'b0;
        bus.Flush_PC     = 32'd0;
        #12;
        check("rst.v0",  {31'd0, bus.Align_Valid0}, 32'd0);
        check("rst.v1",  {31'd0, bus.Align_Valid1}, 32'd0);
        check("rst.pc0", bus.Align_PC0, 32'h0000_0000);
        ready("rst", 1'b1);
        rst_n = 1'b1;

        // Two 32-bit NOPs in one packet.
        cycle(1'b1, 64'h00000013_00000013, 2'd0, 1'b0, 32'd0);
        slot0("t1", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
        slot1("t1", 1'b1, 32'h0000_0013, 32'h4, 1'b0);

        // Two compressed then one 32-bit; take both compressed.
        cycle(1'b0, 64'd0, 2'd0, 1'b1, 32'h0);
        check("t2.flush.v0", {31'd0, bus.Align_Valid0}, 32'd0);
        cycle(1'b1, 64'h00000013_57c157c1, 2'd0, 1'b0, 32'd0);
        slot0("t2a", 1'b1, 32'h0000_57c1, 32'h0, 1'b1);
        slot1("t2a", 1'b1, 32'h0000_57c1, 32'h2, 1'b1);
        cycle(1'b0, 64'd0, 2'd2, 1'b0, 32'd0);
        slot0("t2b", 1'b1, 32'h0000_0013, 32'h4, 1'b0);
        check("t2b.v1", {31'd0, bus.Align_Valid1}, 32'd0);

        // Straddling 32-bit instruction completes with the next packet.
        cycle(1'b0, 64'd0, 2'd0, 1'b1, 32'h0);
        cycle(1'b1, 64'h0013_57c1_57c1_57c1, 2'd0, 1'b0, 32'd0);
        cycle(1'b0, 64'd0, 2'd2, 1'b0, 32'd0);
        slot0("t3a", 1'b1, 32'h0000_57c1, 32'h4, 1'b1);
        check("t3a.v1", {31'd0, bus.Align_Valid1}, 32'd0);
        cycle(1'b1, 64'h0000_0000_0000_0000, 2'd0, 1'b0, 32'd0);
        slot0("t3b", 1'b1, 32'h0000_57c1, 32'h4, 1'b1);
        slot1("t3b", 1'b1, 32'h0000_0013, 32'h6, 1'b0);
        ready("t3b", 1'b0);

        // Full buffer back-pressure.
        cycle(1'b0, 64'd0, 2'd0, 1'b1, 32'h0);
        cycle(1'b1, 64'h00000013_00000013, 2'd0, 1'b0, 32'd0);
        ready("t4.cnt4", 1'b1);
        cycle(1'b1, 64'h00000093_00000013, 2'd0, 1'b0, 32'd0);
        ready("t4.cnt8", 1'b0);
        cycle(1'b1, 64'h57c1_57c1_57c1_57c1, 2'd0, 1'b0, 32'd0);
        slot0("t4.ign", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
        cycle(1'b0, 64'd0, 2'd1, 1'b0, 32'd0);
        ready("t4.cnt6", 1'b0);
        check("t4.cnt6.pc0", bus.Align_PC0, 32'h4);
        cycle(1'b0, 64'd0, 2'd1, 1'b0, 32'd0);
        ready("t4.cnt4b", 1'b1);
        slot0("t4.p2", 1'b1, 32'h0000_0013, 32'h8, 1'b0);
        slot1("t4.p2", 1'b1, 32'h0000_0093, 32'hc, 1'b0);

        // Flush wins over same-cycle enqueue and take; drop below target PC.
        cycle(1'b1, 64'h00000013_00000013, 2'd2, 1'b1, 32'h0000_0106);
        check("t5.v0",  {31'd0, bus.Align_Valid0}, 32'd0);
        check("t5.pc0", bus.Align_PC0, 32'h0000_0106);
        ready("t5", 1'b1);
        cycle(1'b1, 64'h57c1_1111_2222_3333, 2'd0, 1'b0, 32'd0);
        slot0("t5a", 1'b1, 32'h0000_57c1, 32'h106, 1'b1);
        check("t5a.v1", {31'd0, bus.Align_Valid1}, 32'd0);
        cycle(1'b1, 64'h00000013_0000_0093, 2'd0, 1'b0, 32'd0);
        slot1("t5b", 1'b1, 32'h0000_0093, 32'h108, 1'b0);

        // Asynchronous reset mid-cycle with six halfwords buffered.
        cycle(1'b0, 64'd0, 2'd0, 1'b1, 32'h0);
        cycle(1'b1, 64'h00000013_00000013, 2'd0, 1'b0, 32'd0);
        cycle(1'b1, 64'h00000013_00000013, 2'd0, 1'b0, 32'd0);
        cycle(1'b0, 64'd0, 2'd1, 1'b0, 32'd0);
        ready("t6.cnt6", 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.v0",  {31'd0, bus.Align_Valid0}, 32'd0);
        check("t6.pc0", bus.Align_PC0, 32'h0);
        ready("t6", 1'b1);
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 64'h00000013_00000013, 2'd0, 1'b0, 32'd0);
        slot0("t6r", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
        slot1("t6r", 1'b1, 32'h0000_0013, 32'h4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
